// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   In-order pipeline register chain with a valid bit per stage. Stage 0 is the
//   youngest stage and STAGES-1 the oldest. Each stage carries an opaque
//   WIDTH-bit payload. The chain supports stall (backpressure), flush, bubble
//   insertion below a stall point, and a single-step debug advance mode.
//
// Ports
//   clk, aresetn         rising-edge clock, asynchronous active-low reset
//   step_mode, step      1: advance only on a rising edge of step; 0: every cycle
//   in_valid, in_data    payload offered to stage 0
//   in_ready             stage 0 captures in_data this cycle (combinational)
//   stall_req[i]         hold stage i and every younger stage
//   flush_req[i]         kill every stage younger than i
//   out_valid, out_data  valid bit and payload of the oldest stage
//   out_fire             oldest stage retires this cycle (combinational)
//   stage_valid          valid bit of every stage
//   occupancy            registered count of valid stages
//   retire_cnt           wrapping count of retired payloads
//   dbg_sel              stage select for the debug read port
//   dbg_valid, dbg_data  valid bit and payload of stage dbg_sel, 0 if out of range

module pipe_stage_chain #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 64,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         step_mode,
  input  logic                         step,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall_req,
  input  logic [STAGES-1:0]            flush_req,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_fire,
  output logic [STAGES-1:0]            stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             retire_cnt,
  input  logic [SEL_W-1:0]             dbg_sel,
  output logic                         dbg_valid,
  output logic [WIDTH-1:0]             dbg_data
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic                step_q;
  logic                en;
  logic [STAGES-1:0]   v;
  logic [STAGES-1:0]   v_next;
  logic [STAGES-1:0]   busy;
  logic [STAGES-1:0]   kill;
  logic [STAGES-1:0]   load_d;
  logic [WIDTH-1:0]    d [STAGES];
  logic [OCC_W-1:0]    occ_next;

  // Gating en with aresetn keeps in_ready low while reset is held, so every
  // output reads 0 during reset even in free-run mode.
  assign en = aresetn & (step_mode ? (step & ~step_q) : 1'b1);

  // busy[i]: a stall at stage i or any older stage freezes stage i.
  // kill[i]: a flush at any strictly older stage squashes stage i.
  always_comb begin
    busy = '0;
    kill = '0;
    for (int i = 0; i < STAGES; i++) begin
      busy[i] = |(stall_req >> i);
      kill[i] = |(flush_req >> (i + 1));
    end
  end

  // Next valid bits, first matching rule wins: kill, hold, bubble, load.
  // A payload register is written only when a valid item moves into it.
  always_comb begin
    v_next = v;
    load_d = '0;
    if (en) begin
      if (kill[0]) begin
        v_next[0] = 1'b0;
      end else if (!busy[0]) begin
        v_next[0] = in_valid;
        load_d[0] = in_valid;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (kill[i]) begin
          v_next[i] = 1'b0;
        end else if (!busy[i]) begin
          if (busy[i-1]) begin
            v_next[i] = 1'b0;
          end else begin
            v_next[i] = v[i-1];
            load_d[i] = v[i-1];
          end
        end
      end
    end
  end

  // Popcount of the post-update valid bits, registered alongside them.
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_next = occ_next + OCC_W'(v_next[i]);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v          <= '0;
      step_q     <= 1'b0;
      occupancy  <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
      end
    end else begin
      step_q    <= step;
      v         <= v_next;
      occupancy <= occ_next;
      if (out_fire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (load_d[0]) begin
        d[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load_d[i]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign in_ready    = en & ~busy[0] & ~kill[0];
  assign out_fire    = en & v[STAGES-1] & ~busy[STAGES-1];
  assign out_valid   = v[STAGES-1];
  assign out_data    = d[STAGES-1];
  assign stage_valid = v;

  // Debug read port; selections beyond the last stage read as zero.
  always_comb begin
    dbg_valid = 1'b0;
    dbg_data  = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (dbg_sel == SEL_W'(i)) begin
        dbg_valid = v[i];
        dbg_data  = d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
//   Self-checking bench for pipe_stage_chain (STAGES=5, WIDTH=16, CNT_W=4).
//   Inputs change 1ns after each rising edge; outputs are sampled on the
//   falling edge. A scoreboard queue records every accepted payload and
//   checks that retired payloads leave in order, exactly once.

module tb_pipe_stage_chain;

  localparam int STAGES = 5;
  localparam int WIDTH  = 16;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              step_mode;
  logic              step;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [STAGES-1:0] stall_req;
  logic [STAGES-1:0] flush_req;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_fire;
  logic [STAGES-1:0] stage_valid;
  logic [2:0]        occupancy;
  logic [CNT_W-1:0]  retire_cnt;
  logic [SEL_W-1:0]  dbg_sel;
  logic              dbg_valid;
  logic [WIDTH-1:0]  dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } sb_t;

  sb_t sb[$];
  sb_t sb_e;

  typedef struct {
    logic              iv;
    logic [WIDTH-1:0]  id;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic [STAGES-1:0] exp_sv;
    logic              exp_ready;
    logic              exp_fire;
    int                drop;
  } vec_t;

  vec_t tbl[14];

  pipe_stage_chain #(
    .STAGES(STAGES),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .step_mode  (step_mode),
    .step       (step),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall_req  (stall_req),
    .flush_req  (flush_req),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_fire   (out_fire),
    .stage_valid(stage_valid),
    .occupancy  (occupancy),
    .retire_cnt (retire_cnt),
    .dbg_sel    (dbg_sel),
    .dbg_valid  (dbg_valid),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] id,
                               input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl,
                               input logic sm, input logic sp);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    stall_req = st;
    flush_req = fl;
    step_mode = sm;
    step      = sp;
    @(negedge clk);
  endtask

  // Scoreboard: push on acceptance, pop and compare on retirement.
  always @(negedge clk) begin
    if (aresetn) begin
      if (out_fire) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: retired %0d with no payload expected", out_data);
        end else begin
          sb_e = sb.pop_front();
          checkOutput("sb_data", 32'(out_data), 32'(sb_e.data));
          if (lat_chk) checkOutput("latency", cyc - sb_e.acc, 4);
        end
      end
      if (in_valid && in_ready) sb.push_back('{in_data, cyc + 1});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Stall/flush scenario from an empty pipe: expected valid bits observed
    // in each cycle, plus in_ready/out_fire for that cycle's inputs.
    tbl[0]  = '{1'b1, 16'd20, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 16'd21, 5'b00000, 5'b00000, 5'b00001, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 16'd22, 5'b00000, 5'b00000, 5'b00011, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 16'd23, 5'b00000, 5'b00000, 5'b00111, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 16'd24, 5'b00000, 5'b00000, 5'b01111, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b1, 16'd25, 5'b00100, 5'b00000, 5'b11111, 1'b0, 1'b1, 0};
    tbl[6]  = '{1'b1, 16'd25, 5'b00100, 5'b00000, 5'b10111, 1'b0, 1'b1, 0};
    tbl[7]  = '{1'b1, 16'd25, 5'b00100, 5'b00000, 5'b00111, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1, 16'd25, 5'b00000, 5'b00000, 5'b00111, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b1, 16'd26, 5'b00000, 5'b00000, 5'b01111, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b1, 16'd27, 5'b00010, 5'b00100, 5'b11111, 1'b0, 1'b1, 2};
    tbl[11] = '{1'b0, 16'd0,  5'b00000, 5'b00000, 5'b11000, 1'b1, 1'b1, 0};
    tbl[12] = '{1'b0, 16'd0,  5'b00000, 5'b00000, 5'b10000, 1'b1, 1'b1, 0};
    tbl[13] = '{1'b0, 16'd0,  5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 0};

    aresetn   = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    stall_req = '0;
    flush_req = '0;
    dbg_sel   = 3'd0;

    // Reset state
    #12;
    checkOutput("rst_stage_valid", 32'(stage_valid), 0);
    checkOutput("rst_occupancy", 32'(occupancy), 0);
    checkOutput("rst_retire_cnt", 32'(retire_cnt), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    checkOutput("rst_out_fire", 32'(out_fire), 0);
    checkOutput("rst_dbg_data", 32'(dbg_data), 0);
    in_valid = 1'b0;
    #10;
    aresetn = 1'b1;

    // Free-run streaming, fixed four-edge latency checked by the scoreboard
    lat_chk = 1'b1;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b1, 16'(k), '0, '0, 1'b0, 1'b0);
      checkOutput("t1_in_ready", 32'(in_ready), 1);
      checkOutput("t1_occupancy", 32'(occupancy), 32'($countones(stage_valid)));
    end
    applyStimulus(1'b0, 16'd0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, '0, '0, 1'b0, 1'b0);
    checkOutput("t1_retire_cnt_14cyc", 32'(retire_cnt), 10);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'd0, '0, '0, 1'b0, 1'b0);
    checkOutput("t1_retire_cnt_drained", 32'(retire_cnt), 14);
    checkOutput("t1_empty", 32'(stage_valid), 0);
    lat_chk = 1'b0;

    // Stall with a full pipe, then flush beating stall
    for (int r = 0; r < 14; r++) begin
      applyStimulus(tbl[r].iv, tbl[r].id, tbl[r].stall, tbl[r].flush, 1'b0, 1'b0);
      checkOutput($sformatf("t23_stage_valid[%0d]", r), 32'(stage_valid), 32'(tbl[r].exp_sv));
      checkOutput($sformatf("t23_in_ready[%0d]", r), 32'(in_ready), 32'(tbl[r].exp_ready));
      checkOutput($sformatf("t23_out_fire[%0d]", r), 32'(out_fire), 32'(tbl[r].exp_fire));
      checkOutput($sformatf("t23_occupancy[%0d]", r), 32'(occupancy), 32'($countones(tbl[r].exp_sv)));
      repeat (tbl[r].drop) void'(sb.pop_back());
    end
    checkOutput("t23_retire_cnt", 32'(retire_cnt), 3);

    // Step mode: a held button gives one advance, then three pulses
    for (int t = 0; t < 20; t++) begin
      applyStimulus(1'b1, 16'(50 + t), '0, '0, 1'b1, 1'b1);
      checkOutput("t4_held_in_ready", 32'(in_ready), (t == 0) ? 1 : 0);
      checkOutput("t4_held_out_fire", 32'(out_fire), 0);
    end
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 16'(80 + 2 * p), '0, '0, 1'b1, 1'b0);
      checkOutput("t4_low_in_ready", 32'(in_ready), 0);
      applyStimulus(1'b1, 16'(81 + 2 * p), '0, '0, 1'b1, 1'b1);
      checkOutput("t4_pulse_in_ready", 32'(in_ready), 1);
      checkOutput("t4_pulse_out_fire", 32'(out_fire), 0);
    end
    applyStimulus(1'b0, 16'd0, '0, '0, 1'b1, 1'b0);
    checkOutput("t4_stage_valid", 32'(stage_valid), 32'b01111);
    checkOutput("t4_occupancy", 32'(occupancy), 4);
    // Back to free-run; the four stepped payloads must drain in order
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'd0, '0, '0, 1'b0, 1'b0);
    checkOutput("t4_drained", 32'(stage_valid), 0);
    checkOutput("t4_retire_cnt", 32'(retire_cnt), 7);

    // Asynchronous reset mid-stream, asserted between clock edges
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'(60 + k), '0, '0, 1'b0, 1'b0);
    dbg_sel = 3'd1;
    #2;
    aresetn  = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    checkOutput("t5_stage_valid", 32'(stage_valid), 0);
    checkOutput("t5_out_valid", 32'(out_valid), 0);
    checkOutput("t5_occupancy", 32'(occupancy), 0);
    checkOutput("t5_retire_cnt", 32'(retire_cnt), 0);
    checkOutput("t5_in_ready", 32'(in_ready), 0);
    checkOutput("t5_dbg_valid", 32'(dbg_valid), 0);
    checkOutput("t5_dbg_data", 32'(dbg_data), 0);
    #9;
    aresetn = 1'b1;

    // 17 retires wrap the 4-bit counter to 1; debug port checks on the way
    lat_chk = 1'b1;
    for (int j = 0; j < 17; j++) begin
      applyStimulus(1'b1, 16'(70 + j), '0, '0, 1'b0, 1'b0);
      if (j == 8) begin
        dbg_sel = 3'd3;
        #1;
        checkOutput("t6_dbg3_valid", 32'(dbg_valid), 1);
        checkOutput("t6_dbg3_data", 32'(dbg_data), 74);
        dbg_sel = 3'd7;
        #1;
        checkOutput("t6_dbg7_valid", 32'(dbg_valid), 0);
        checkOutput("t6_dbg7_data", 32'(dbg_data), 0);
      end
    end
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'd0, '0, '0, 1'b0, 1'b0);
    checkOutput("t6_retire_wrap", 32'(retire_cnt), 1);
    checkOutput("t6_drained", 32'(stage_valid), 0);
    checkOutput("sb_leftover", sb.size(), 0);
    lat_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
